mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter for the single-port data memory, sharing it between the CPU load/store path (driven by the controller's LOAD/STOR phases) and the VGA frame reader. It runs one memory access at a time through a small issue/response state machine. It gives the real-time VGA port priority, can optionally guard the CPU against starvation, and returns registered read data with a one-cycle valid pulse.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- STARVE_MAX, 4, consecutive VGA grants allowed while CPU waits (used only with guard enabled)

- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU access issued
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_rd_valid  out  1  one-cycle pulse: cpu_rdata valid
- vga_req  in  1  VGA read request, held until vga_ack
- vga_addr  in  ADDR_W  VGA address
- vga_ack  out  1  one-cycle pulse: VGA read issued
- vga_rdata  out  DATA_W  VGA read data, registered
- vga_rd_valid  out  1  one-cycle pulse: vga_rdata valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en

## Operation
- All outputs are registered. Reset value is 0 for every output. The FSM resets to IDLE and the starve counter resets to 0.
- The FSM has five states: IDLE, C_ISSUE, V_ISSUE, C_RESP, V_RESP.
- Arbitration runs in IDLE and in both RESP states:
  - If vga_req=1, go to V_ISSUE.
  - Else if cpu_req=1, go to C_ISSUE.
  - Else go to IDLE.
- In an ISSUE state:
  - mem_en=1; mem_addr and mem_wdata are taken from the winning port.
  - mem_we=cpu_we in C_ISSUE and 0 in V_ISSUE.
  - The winner's ack is 1.
  - Next state is the matching RESP.
- In a RESP state:
  - mem_en=0 and mem_we=0.
  - mem_rdata is captured into the winner's rdata register at the end of the cycle, but only for reads.
  - The winner's rd_valid pulses in the following cycle.
  - A CPU write never produces cpu_rd_valid.
- Requester rule: req, we, addr and wdata stay stable until ack. The requester may drop or change them after the ack cycle. Because RESP samples req after ack, a single request is never granted twice.
- The rdata registers hold their value until the next read for the same port.
- Reset mid-operation: the in-flight access is abandoned and no rd_valid is produced. An ISSUE cycle already on the bus in the cycle where reset is sampled low still completes at memory.

## Timing
- Read: req sampled at edge N. ack and mem_en are seen in cycle N+1, RESP in N+2, and rd_valid plus rdata in N+3.
- Write: ack and mem_we in N+1. The memory is updated at the end of N+1.
- Throughput: one access per 2 cycles. Back-to-back accesses run ISSUE, RESP, ISSUE, ... with no IDLE in between.
- A read-valid pulse from the previous access can coincide with the next ISSUE cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - The counter increments on each V_ISSUE entry while cpu_req=1.
  - When the counter equals STARVE_MAX and cpu_req=1, the next arbitration grants the CPU regardless of vga_req.
  - The counter clears on C_ISSUE or whenever cpu_req=0.
- ARB_STARVE_GUARD_EN not defined: strict VGA priority. The counter logic is absent, and the CPU is never granted while vga_req stays high.

## Test plan
- CPU read: memory holds 0x0010=0xBEEF; cpu_req at edge 0 → cpu_ack and mem_addr=0x0010 in cycle 1; cpu_rd_valid=1 with cpu_rdata=0xBEEF in cycle 3; no VGA outputs toggle.
- CPU write then read: write 0x1234 to 0x0020 → mem_we=1 only in the ack cycle and no cpu_rd_valid; a following read of 0x0020 returns 0x1234.
- Simultaneous requests: cpu_req and vga_req at edge 0 → vga_ack in cycle 1 and cpu_ack in cycle 3; each rd_valid arrives 2 cycles after its ack.
- Starvation (macro defined, STARVE_MAX=4): vga_req and cpu_req held high → exactly 4 vga_acks, then cpu_ack, then VGA resumes. Same stimulus without the macro → no cpu_ack over 100 cycles.
- Reset mid-read: reset low during V_RESP → next cycle all outputs are 0, no vga_rd_valid, FSM in IDLE; a new cpu_req after reset is served with the normal read latency.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port data memory between the CPU and VGA ports.
//            VGA has priority. The optional CPU starvation guard is enabled by
//            defining ARB_STARVE_GUARD_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rd_valid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_ISSUE = 3'd1,
    V_ISSUE = 3'd2,
    C_RESP  = 3'd3,
    V_RESP  = 3'd4
  } state_t;

  state_t state;
  logic   resp_read;
  logic   cpu_wins;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 2);
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved  = cpu_req && (starve_cnt == CNT_W'(STARVE_MAX));
  assign cpu_wins = cpu_req && (!vga_req || starved);
`else
  logic unused_starve_max;

  assign unused_starve_max = |STARVE_MAX;
  assign cpu_wins          = cpu_req && !vga_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      resp_read    <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      cpu_rd_valid <= 1'b0;
      vga_ack      <= 1'b0;
      vga_rdata    <= '0;
      vga_rd_valid <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt   <= '0;
`endif
    end else begin
      cpu_ack      <= 1'b0;
      vga_ack      <= 1'b0;
      cpu_rd_valid <= 1'b0;
      vga_rd_valid <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;

      case (state)
        IDLE, C_RESP, V_RESP: begin
          // The memory drives read data during RESP; capture it here.
          if (resp_read && state == C_RESP) begin
            cpu_rdata    <= mem_rdata;
            cpu_rd_valid <= 1'b1;
          end
          if (resp_read && state == V_RESP) begin
            vga_rdata    <= mem_rdata;
            vga_rd_valid <= 1'b1;
          end

          if (cpu_wins) begin
            state     <= C_ISSUE;
            cpu_ack   <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            resp_read <= !cpu_we;
          end else if (vga_req) begin
            state     <= V_ISSUE;
            vga_ack   <= 1'b1;
            mem_en    <= 1'b1;
            mem_addr  <= vga_addr;
            mem_wdata <= '0;
            resp_read <= 1'b1;
          end else begin
            state     <= IDLE;
            resp_read <= 1'b0;
          end

`ifdef ARB_STARVE_GUARD_EN
          if (!cpu_req || cpu_wins) begin
            starve_cnt <= '0;
          end else if (vga_req) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
`endif
        end

        C_ISSUE: begin
          state <= C_RESP;
`ifdef ARB_STARVE_GUARD_EN
          starve_cnt <= '0;
`endif
        end

        V_ISSUE: begin
          state <= V_RESP;
`ifdef ARB_STARVE_GUARD_EN
          if (!cpu_req) starve_cnt <= '0;
`endif
        end

        default: begin
          state <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
          starve_cnt <= '0;
`endif
        end
      endcase
    end
  end

endmodule
`default_nettype wire
